fir_decim_out: RTL and testbench

//   Output stage directly downstream of the FIR tap chain. Takes the FIR

---
 rtl/fir_pkg.sv | 46 ++++
 rtl/sync_fifo_fwft.sv | 71 +++++++
 rtl/fir_decim_out.sv | 124 ++++++++++++
 tb/tb_fir_decim_out.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: default widths and the round/saturate helper.
// Also used by the fir_filter testbenches, so keep the function free of module state.
package fir_pkg;

    localparam int DEFAULT_DATA_WIDTH = 24;
    localparam int DEFAULT_OUT_WIDTH  = 16;
    localparam int SR_WIDTH           = 64;

    typedef struct packed {
        logic                       sat;
        logic signed [SR_WIDTH-1:0] value;
    } sat_round_t;

    // Round half toward +inf by adding half an LSB before the arithmetic shift,
    // then clamp to the signed range of outWidth bits.
    function automatic sat_round_t sat_round(input logic signed [SR_WIDTH-1:0] din,
                                             input int shift,
                                             input int outWidth);
        logic signed [SR_WIDTH:0] one;
        logic signed [SR_WIDTH:0] t;
        logic signed [SR_WIDTH:0] r;
        logic signed [SR_WIDTH:0] maxV;
        logic signed [SR_WIDTH:0] minV;
        sat_round_t               res;
        one    = '0;
        one[0] = 1'b1;
        t      = {din[SR_WIDTH-1], din};
        if (shift > 0) begin
            t = t + (one <<< (shift - 1));
        end
        r    = t >>> shift;
        maxV = (one <<< (outWidth - 1)) - one;
        minV = -(one <<< (outWidth - 1));
        res.sat = 1'b0;
        if (r > maxV) begin
            r       = maxV;
            res.sat = 1'b1;
        end else if (r < minV) begin
            r       = minV;
            res.sat = 1'b1;
        end
        res.value = r[SR_WIDTH-1:0];
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; the head entry is visible whenever non-empty.
// Pointers carry an extra wrap bit; count and full are registered alongside them.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         iv_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         ov_rd_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   ov_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full_q;
    logic             doRead;
    logic             doWrite;

    assign o_empty    = (wrPtr_q == rdPtr_q);
    assign o_full     = full_q;
    assign ov_count   = count_q;
    assign ov_rd_data = o_empty ? '0 : mem_q[rdPtr_q[AW-1:0]];

    // A write into a full FIFO is only taken when the head leaves on the same edge.
    assign doRead  = i_rd_en && !o_empty;
    assign doWrite = i_wr_en && (!full_q || doRead);

    always_comb begin
        count_d = count_q;
        if (doWrite && !doRead) begin
            count_d = count_q + 1'b1;
        end else if (doRead && !doWrite) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (doWrite) begin
            mem_q[wrPtr_q[AW-1:0]] <= iv_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (doWrite) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doRead) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/fir_decim_out.sv
// FIR output stage: decimate, round/saturate to OUT_WIDTH, buffer in a FWFT FIFO,
// and fold the per-tap overflow vectors plus local drop/saturation events into sticky flags.
module fir_decim_out
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int OUT_WIDTH  = DEFAULT_OUT_WIDTH,
    parameter int FIR_DEPTH  = 128,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic                          i_din_valid,
    input  logic signed [DATA_WIDTH-1:0]  iv_din,
    input  logic [FIR_DEPTH-1:0]          iv_prod_overflow,
    input  logic [FIR_DEPTH-1:0]          iv_sum_overflow,
    input  logic                          i_clr_sticky,
    input  logic                          i_dout_ready,
    output logic                          o_dout_valid,
    output logic signed [OUT_WIDTH-1:0]   ov_dout,
    output logic [$clog2(FIFO_DEPTH):0]   ov_fifo_count,
    output logic                          o_fifo_full,
    output logic                          o_drop_sticky,
    output logic                          o_sat_sticky,
    output logic                          o_ovf_sticky
);

    localparam int SHIFT = DATA_WIDTH - OUT_WIDTH;
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PH_W-1:0]          phase_q;
    logic [PH_W-1:0]          phase_d;
    logic                     accept;
    logic                     keep;
    sat_round_t               rounded;
    logic                     unusedRoundBits;
    logic [OUT_WIDTH-1:0]     round_q;
    logic                     roundValid_q;
    logic                     fifoEmpty;
    logic                     fifoFull;
    logic                     fifoRdEn;
    logic                     dropEvent;
    logic                     dropSticky_q;
    logic                     dropSticky_d;
    logic                     satSticky_q;
    logic                     satSticky_d;
    logic                     ovfSticky_q;
    logic                     ovfSticky_d;

    assign accept  = i_en && i_din_valid;
    assign keep    = accept && (phase_q == '0);
    assign rounded = sat_round(SR_WIDTH'(iv_din), SHIFT, OUT_WIDTH);
    assign unusedRoundBits = ^rounded.value[SR_WIDTH-1:OUT_WIDTH];

    // Phase 0 marks a kept sample, so the first accept after reset is always kept.
    always_comb begin
        phase_d = phase_q;
        if (accept) begin
            phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase_q      <= '0;
            round_q      <= '0;
            roundValid_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            roundValid_q <= keep;
            if (keep) begin
                round_q <= rounded.value[OUT_WIDTH-1:0];
            end
        end
    end

    // The round register drains into the FIFO one edge later regardless of i_en.
    sync_fifo_fwft #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_en    (roundValid_q),
        .iv_wr_data (round_q),
        .i_rd_en    (fifoRdEn),
        .ov_rd_data (ov_dout),
        .o_empty    (fifoEmpty),
        .o_full     (fifoFull),
        .ov_count   (ov_fifo_count)
    );

    assign o_dout_valid = !fifoEmpty;
    assign o_fifo_full  = fifoFull;
    assign fifoRdEn     = o_dout_valid && i_dout_ready;
    assign dropEvent    = roundValid_q && fifoFull && !fifoRdEn;

    // A set in the same cycle as a clear wins, so no event is ever lost.
    always_comb begin
        dropSticky_d = (dropSticky_q && !i_clr_sticky) || dropEvent;
        satSticky_d  = (satSticky_q && !i_clr_sticky) || (keep && rounded.sat);
        ovfSticky_d  = (ovfSticky_q && !i_clr_sticky) ||
                       (i_en && |(iv_prod_overflow | iv_sum_overflow));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dropSticky_q <= 1'b0;
            satSticky_q  <= 1'b0;
            ovfSticky_q  <= 1'b0;
        end else begin
            dropSticky_q <= dropSticky_d;
            satSticky_q  <= satSticky_d;
            ovfSticky_q  <= ovfSticky_d;
        end
    end

    assign o_drop_sticky = dropSticky_q;
    assign o_sat_sticky  = satSticky_q;
    assign o_ovf_sticky  = ovfSticky_q;

endmodule

// File: tb/tb_fir_decim_out.sv
// Scoreboard bench for fir_decim_out: a DECIM=4 instance for the main scenarios and a
// DECIM=1 instance for the rounding/saturation vectors; monitors pop expected samples.
module tb_fir_decim_out;

    localparam int DW = 24;
    localparam int OW = 16;
    localparam int FD = 128;
    localparam int CW = 4;

    typedef struct {
        logic [OW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 en;
    logic                 clrSticky;
    logic                 ready;
    logic                 dinValid;
    logic signed [DW-1:0] din;
    logic [FD-1:0]        prodOvf;
    logic [FD-1:0]        sumOvf;
    logic                 doutValid;
    logic [OW-1:0]        dout;
    logic [CW-1:0]        fifoCount;
    logic                 fifoFull;
    logic                 dropSticky;
    logic                 satSticky;
    logic                 ovfSticky;

    logic                 d1Valid;
    logic signed [DW-1:0] d1Din;
    logic                 d1DoutValid;
    logic [OW-1:0]        d1Dout;
    logic [CW-1:0]        d1Count;
    logic                 d1Full;
    logic                 d1Drop;
    logic                 d1Sat;
    logic                 d1Ovf;

    exp_t expQ[$];
    exp_t d1Q[$];
    exp_t mainHead;
    exp_t d1Head;
    int   cycleCount  = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    fir_decim_out #(
        .DATA_WIDTH (DW), .OUT_WIDTH (OW), .FIR_DEPTH (FD), .DECIM (4), .FIFO_DEPTH (8)
    ) dut (
        .i_clk (clk), .i_rst (rst), .i_en (en), .i_din_valid (dinValid), .iv_din (din),
        .iv_prod_overflow (prodOvf), .iv_sum_overflow (sumOvf), .i_clr_sticky (clrSticky),
        .i_dout_ready (ready), .o_dout_valid (doutValid), .ov_dout (dout),
        .ov_fifo_count (fifoCount), .o_fifo_full (fifoFull), .o_drop_sticky (dropSticky),
        .o_sat_sticky (satSticky), .o_ovf_sticky (ovfSticky)
    );

    fir_decim_out #(
        .DATA_WIDTH (DW), .OUT_WIDTH (OW), .FIR_DEPTH (FD), .DECIM (1), .FIFO_DEPTH (8)
    ) dutD1 (
        .i_clk (clk), .i_rst (rst), .i_en (en), .i_din_valid (d1Valid), .iv_din (d1Din),
        .iv_prod_overflow ('0), .iv_sum_overflow ('0), .i_clr_sticky (clrSticky),
        .i_dout_ready (1'b1), .o_dout_valid (d1DoutValid), .ov_dout (d1Dout),
        .ov_fifo_count (d1Count), .o_fifo_full (d1Full), .o_drop_sticky (d1Drop),
        .o_sat_sticky (d1Sat), .o_ovf_sticky (d1Ovf)
    );

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    // Main-instance monitor: every handshake must match the oldest expected sample.
    always @(negedge clk) begin
        if (!rst && doutValid && ready) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_output: got %0h, expected nothing", dout);
            end else begin
                mainHead = expQ.pop_front();
                checkOutput("dout", 32'(dout), 32'(mainHead.data));
                if (mainHead.due >= 0) checkOutput("dout_latency", 32'(cycleCount), 32'(mainHead.due));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && d1DoutValid) begin
            if (d1Q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_d1_output: got %0h, expected nothing", d1Dout);
            end else begin
                d1Head = d1Q.pop_front();
                checkOutput("d1_dout", 32'(d1Dout), 32'(d1Head.data));
                if (d1Head.due >= 0) checkOutput("d1_latency", 32'(cycleCount), 32'(d1Head.due));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit toD1, input logic [DW-1:0] sample, input bit keep,
                                 input logic [OW-1:0] expVal, input bit checkLat);
        exp_t e;
        e.data = expVal;
        e.due  = checkLat ? cycleCount + 2 : -1;
        if (toD1) begin
            d1Valid = 1'b1;
            d1Din   = sample;
            if (keep) d1Q.push_back(e);
        end else begin
            dinValid = 1'b1;
            din      = sample;
            if (keep) expQ.push_back(e);
        end
        tick(1);
        d1Valid  = 1'b0;
        dinValid = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expQ.delete();
        d1Q.delete();
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while ((expQ.size() != 0 || d1Q.size() != 0) && guard < 60) begin
            tick(1);
            guard++;
        end
        checkOutput("drain_pending", 32'(expQ.size() + d1Q.size()), 32'd0);
        tick(2);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; clrSticky = 1'b0; ready = 1'b1;
        dinValid = 1'b0; din = '0; prodOvf = '0; sumOvf = '0;
        d1Valid = 1'b0; d1Din = '0;
        tick(2);
        checkOutput("rst_valid", 32'(doutValid), 32'd0);
        checkOutput("rst_dout", 32'(dout), 32'd0);
        checkOutput("rst_count", 32'(fifoCount), 32'd0);
        checkOutput("rst_full", 32'(fifoFull), 32'd0);
        checkOutput("rst_drop", 32'(dropSticky), 32'd0);
        checkOutput("rst_sat", 32'(satSticky), 32'd0);
        checkOutput("rst_ovf", 32'(ovfSticky), 32'd0);
        rst = 1'b0;
        en  = 1'b1;

        $display("[TB] rounding and saturation, DECIM=1");
        applyStimulus(1'b1, 24'h000180, 1'b1, 16'h0002, 1'b1);
        applyStimulus(1'b1, 24'hFFFE80, 1'b1, 16'hFFFF, 1'b1);
        applyStimulus(1'b1, 24'h00017F, 1'b1, 16'h0001, 1'b1);
        applyStimulus(1'b1, 24'h800000, 1'b1, 16'h8000, 1'b1);
        tick(2);
        checkOutput("d1_sat_after_min", 32'(d1Sat), 32'd0);
        applyStimulus(1'b1, 24'h7FFFFF, 1'b1, 16'h7FFF, 1'b1);
        tick(1);
        checkOutput("d1_sat_after_max", 32'(d1Sat), 32'd1);
        checkOutput("main_sat_untouched", 32'(satSticky), 32'd0);
        waitDrain();

        $display("[TB] decimation by 4");
        doReset();
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0, DW'(k << 8), (k % 4) == 1, OW'(k), 1'b1);
        end
        waitDrain();

        $display("[TB] backpressure with overflow");
        doReset();
        ready = 1'b0;
        for (int j = 0; j < 40; j++) begin
            applyStimulus(1'b0, DW'((j + 1) << 8), (j % 4 == 0) && (j < 32), OW'(j + 1), 1'b0);
        end
        tick(3);
        checkOutput("bp_count", 32'(fifoCount), 32'd8);
        checkOutput("bp_full", 32'(fifoFull), 32'd1);
        checkOutput("bp_drop", 32'(dropSticky), 32'd1);
        ready = 1'b1;
        waitDrain();
        checkOutput("bp_count_after", 32'(fifoCount), 32'd0);
        checkOutput("bp_full_after", 32'(fifoFull), 32'd0);

        $display("[TB] full with simultaneous read and write, enable gating");
        doReset();
        ready = 1'b0;
        for (int j = 0; j < 32; j++) begin
            applyStimulus(1'b0, DW'((j + 1) << 8), j % 4 == 0, OW'(j + 1), 1'b0);
        end
        tick(3);
        checkOutput("fill_count", 32'(fifoCount), 32'd8);
        checkOutput("fill_drop", 32'(dropSticky), 32'd0);
        applyStimulus(1'b0, DW'(100 << 8), 1'b1, OW'(100), 1'b0);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        checkOutput("rw_count", 32'(fifoCount), 32'd8);
        checkOutput("rw_full", 32'(fifoFull), 32'd1);
        checkOutput("rw_drop", 32'(dropSticky), 32'd0);
        en = 1'b0;
        dinValid = 1'b1;
        din = DW'(200 << 8);
        tick(5);
        dinValid = 1'b0;
        en = 1'b1;
        checkOutput("en_low_count", 32'(fifoCount), 32'd8);
        checkOutput("en_low_drop", 32'(dropSticky), 32'd0);
        ready = 1'b1;
        waitDrain();
        for (int m = 0; m < 4; m++) begin
            applyStimulus(1'b0, DW'((300 + m) << 8), m == 3, OW'(300 + m), 1'b1);
        end
        waitDrain();

        $display("[TB] sticky flags and mid-stream reset");
        doReset();
        checkOutput("ovf_clear_start", 32'(ovfSticky), 32'd0);
        sumOvf[37] = 1'b1;
        tick(1);
        sumOvf = '0;
        checkOutput("ovf_set", 32'(ovfSticky), 32'd1);
        sumOvf[37] = 1'b1;
        clrSticky = 1'b1;
        tick(1);
        clrSticky = 1'b0;
        sumOvf = '0;
        checkOutput("ovf_set_beats_clear", 32'(ovfSticky), 32'd1);
        clrSticky = 1'b1;
        tick(1);
        clrSticky = 1'b0;
        checkOutput("ovf_cleared", 32'(ovfSticky), 32'd0);
        en = 1'b0;
        prodOvf[5] = 1'b1;
        tick(1);
        prodOvf = '0;
        en = 1'b1;
        checkOutput("ovf_ignored_en_low", 32'(ovfSticky), 32'd0);
        prodOvf[127] = 1'b1;
        tick(1);
        prodOvf = '0;
        checkOutput("ovf_prod_msb", 32'(ovfSticky), 32'd1);

        ready = 1'b0;
        for (int j = 0; j < 18; j++) begin
            applyStimulus(1'b0, DW'((j + 1) << 8), j % 4 == 0, OW'(j + 1), 1'b0);
        end
        tick(3);
        checkOutput("pre_rst_count", 32'(fifoCount), 32'd5);
        doReset();
        checkOutput("post_rst_valid", 32'(doutValid), 32'd0);
        checkOutput("post_rst_count", 32'(fifoCount), 32'd0);
        checkOutput("post_rst_ovf", 32'(ovfSticky), 32'd0);
        ready = 1'b1;
        applyStimulus(1'b0, 24'h001234, 1'b1, 16'h0012, 1'b1);
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
